// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage. Generates the PC, issues in-order
// reads to program memory under a credit limit, buffers returned words in a
// first-word-fall-through prefetch FIFO and hands them to the decoder.
// Branch redirect flushes the FIFO and drops responses still in flight.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
module instruction_fetch #(
    parameter int                ADDR_W     = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [15:0]       mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;          // next address to request
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;  // address of the next kept response
    logic [CNT_W-1:0]  outst_q, outst_d;    // requests accepted, response pending
    logic [CNT_W-1:0]  drop_q, drop_d;      // pending responses to discard
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // FIFO occupancy
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    logic [15:0]       data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_mem  [FIFO_DEPTH];

    logic [CNT_W:0]    inflight;
    logic              credit_ok;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    // Words buffered plus words in flight may never exceed the FIFO size, so a
    // returning response always has a slot.
    assign inflight   = {1'b0, cnt_q} + {1'b0, outst_q};
    assign credit_ok  = inflight < DEPTH_C;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_C);

    assign mem_req_valid = (state_q == S_RUN) && !halt && credit_ok && !redirect_valid;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response arriving in the redirect cycle belongs to the old stream.
    assign push = mem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign instr_valid = !fifo_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instruction = fifo_empty ? '0 : data_mem[rd_ptr_q];
    assign instr_pc    = fifo_empty ? '0 : tag_mem[rd_ptr_q];

    // Next-state for PC, credit counters and FIFO pointers; redirect wins over all.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (req_fire) begin
            pc_d    = pc_q + PC_ONE;
            outst_d = outst_d + CNT_ONE;
        end
        if (mem_rsp_valid) begin
            outst_d = outst_d - CNT_ONE;
        end
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            drop_d   = outst_d;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (mem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_ONE;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rsp_pc_d = rsp_pc_q + PC_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Fetch control FSM; redirect forces RUN for one cycle, halt re-applies after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (redirect_valid) begin
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_RUN;
                S_RUN:    if (halt) state_q <= S_HALTED;
                S_HALTED: if (!halt) state_q <= S_RUN;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Control registers: PC, response tag, credit counters, FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rsp_data;
            tag_mem[wr_ptr_q]  <= rsp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic        stall_cyc;

    assign stall_cyc = instr_ready && !instr_valid && (state_q != S_IDLE);

    // Saturating counters: delivered instructions and decoder-starved cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop) perf_fetched_q <= sat_inc(perf_fetched_q);
            if (stall_cyc) perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: program memory model with configurable
// latency and request budget, directed scenarios per feature.
module tb_instruction_fetch;

    localparam int          ADDR_W     = 16;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] RP         = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [15:0] mem_rsp_data = 16'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instruction;
    logic [15:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          mem_lat = 1;
    int          budget = 1000000;
    int          lat_plan[$];
    logic [15:0] q_addr[$];
    int          q_due[$];
    logic [15:0] iss_log[$];
    logic [15:0] pop_pc[$];
    logic [15:0] pop_data[$];
    int          pop_cyc[$];

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RP)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    // Program memory: word at address A holds A + 16'h1000; in-order responses.
    always @(posedge clk) begin
        int lat;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (mem_rsp_valid) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                lat = mem_lat;
                if (lat_plan.size() > 0) lat = lat_plan.pop_front();
                q_addr.push_back(mem_req_addr);
                q_due.push_back(cyc + lat);
                iss_log.push_back(mem_req_addr);
                budget--;
            end
            if (instr_valid && instr_ready) begin
                pop_pc.push_back(instr_pc);
                pop_data.push_back(instruction);
                pop_cyc.push_back(cyc);
            end
        end
        cyc++;
        #1;
        mem_rsp_valid = (q_addr.size() > 0) && (q_due[0] <= cyc);
        mem_rsp_data  = mem_rsp_valid ? q_addr[0] + 16'h1000 : 16'h0;
        mem_req_ready = (budget > 0);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; instr_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0;
        budget = 1000000; mem_lat = 1; lat_plan.delete();
        repeat (3) @(negedge clk);
        iss_log.delete(); pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        budget = 1000000; mem_lat = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0h exp=0", mem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%0h exp=0", instr_valid); end
        checks++; if (instruction !== 16'h0) begin failures++; $display("FAIL rst_instruction got=%h exp=0000", instruction); end
        checks++; if (instr_pc !== 16'h0) begin failures++; $display("FAIL rst_instr_pc got=%h exp=0000", instr_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_fetched !== 32'h0) begin failures++; $display("FAIL rst_perf_fetched got=%0d exp=0", perf_fetched); end
        checks++; if (perf_stall !== 32'h0) begin failures++; $display("FAIL rst_perf_stall got=%0d exp=0", perf_stall); end
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_req_valid got=%0h exp=0", mem_req_valid); end
        @(negedge clk);
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL run_req_valid got=%0h exp=1", mem_req_valid); end
        checks++; if (mem_req_addr !== RP) begin failures++; $display("FAIL run_req_addr got=%h exp=%h", mem_req_addr, RP); end
    endtask

    task automatic test_stream_wrap();
        logic [15:0] exp_pc [8] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        logic [15:0] exp_dt [8] = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 60 && pop_pc.size() < 8; k++) @(negedge clk);
        checks++;
        if (pop_pc.size() < 8) begin
            failures++; $display("FAIL stream_pop_count got=%0d exp>=8", pop_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (iss_log[i] !== exp_pc[i]) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, iss_log[i], exp_pc[i]); end
                checks++; if (pop_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pop_pc[i], exp_pc[i]); end
                checks++; if (pop_data[i] !== exp_dt[i]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, pop_data[i], exp_dt[i]); end
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != 1) begin
                    failures++; $display("FAIL stream_rate[%0d] got=%0d exp=1", i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_pc [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        do_reset();
        mem_lat = 3;
        repeat (20) @(negedge clk);
        #1;
        checks++; if (iss_log.size() != 4) begin failures++; $display("FAIL bp_issue_count got=%0d exp=4", iss_log.size()); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0h exp=0", mem_req_valid); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_instr_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr_pc !== 16'hFFFE) begin failures++; $display("FAIL bp_head_pc got=%h exp=fffe", instr_pc); end
        instr_ready = 1'b1;
        for (int k = 0; k < 40 && pop_pc.size() < 6; k++) @(negedge clk);
        checks++;
        if (pop_pc.size() < 6 || iss_log.size() < 6) begin
            failures++; $display("FAIL bp_resume_count got=%0d exp>=6", pop_pc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (iss_log[i] !== exp_pc[i]) begin failures++; $display("FAIL bp_addr[%0d] got=%h exp=%h", i, iss_log[i], exp_pc[i]); end
                checks++; if (pop_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL bp_pc[%0d] got=%h exp=%h", i, pop_pc[i], exp_pc[i]); end
            end
        end
    endtask

    task automatic test_redirect();
        logic [15:0] exp_pc [4] = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
        int k;
        do_reset();
        budget = 3;
        lat_plan = '{1, 8, 9};
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) break;
        end
        checks++; if (k >= 20) begin failures++; $display("FAIL redir_first_word got=timeout exp=valid"); end
        @(negedge clk);
        checks++; if (iss_log.size() != 3) begin failures++; $display("FAIL redir_issued got=%0d exp=3", iss_log.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_instr_valid got=%0h exp=0", instr_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_valid got=%0h exp=0", mem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        budget = 4;
        mem_lat = 1;
        instr_ready = 1'b1;
        for (int j = 0; j < 60 && pop_pc.size() < 4; j++) @(negedge clk);
        checks++;
        if (pop_pc.size() < 4) begin
            failures++; $display("FAIL redir_pop_count got=%0d exp>=4", pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (pop_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL redir_pc[%0d] got=%h exp=%h", i, pop_pc[i], exp_pc[i]); end
                checks++; if (pop_data[i] !== exp_pc[i] + 16'h1000) begin failures++; $display("FAIL redir_data[%0d] got=%h exp=%h", i, pop_data[i], exp_pc[i] + 16'h1000); end
            end
            checks++; if (iss_log[3] !== 16'h0040) begin failures++; $display("FAIL redir_addr got=%h exp=0040", iss_log[3]); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (10) @(negedge clk);
        halt = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_req_valid[%0d] got=%0h exp=0", c, mem_req_valid); end
            @(negedge clk);
        end
        checks++; if (pop_pc.size() != 4) begin failures++; $display("FAIL halt_drained got=%0d exp=4", pop_pc.size()); end
        checks++; if (iss_log.size() != 4) begin failures++; $display("FAIL halt_issued got=%0d exp=4", iss_log.size()); end
        halt = 1'b0;
        for (int j = 0; j < 30 && pop_pc.size() < 5; j++) @(negedge clk);
        checks++;
        if (pop_pc.size() < 5 || iss_log.size() < 5) begin
            failures++; $display("FAIL halt_resume_count got=%0d exp>=5", pop_pc.size());
        end else begin
            checks++; if (iss_log[4] !== 16'h0002) begin failures++; $display("FAIL halt_resume_addr got=%h exp=0002", iss_log[4]); end
            checks++; if (pop_pc[4] !== 16'h0002) begin failures++; $display("FAIL halt_resume_pc got=%h exp=0002", pop_pc[4]); end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        budget = 4;
        #1;
        checks++; if (perf_fetched !== 32'd0) begin failures++; $display("FAIL perf_fetched_init got=%0d exp=0", perf_fetched); end
        @(negedge clk);
        repeat (10) @(negedge clk);
        instr_ready = 1'b1; repeat (4) @(negedge clk); instr_ready = 1'b0;
        instr_ready = 1'b1; repeat (3) @(negedge clk); instr_ready = 1'b0;
        budget = 4; repeat (10) @(negedge clk);
        instr_ready = 1'b1; repeat (4) @(negedge clk); instr_ready = 1'b0;
        budget = 2; repeat (10) @(negedge clk);
        instr_ready = 1'b1; repeat (2) @(negedge clk); instr_ready = 1'b0;
        #1;
        checks++; if (perf_fetched !== 32'd10) begin failures++; $display("FAIL perf_fetched got=%0d exp=10", perf_fetched); end
        checks++; if (perf_stall !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", perf_stall); end
        checks++; if (pop_pc.size() != 10) begin failures++; $display("FAIL perf_pops got=%0d exp=10", pop_pc.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream_wrap();
        test_backpressure();
        test_redirect();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
